// File: rtl/clap_sequence_detector_if.sv
// Sample-side and event-side signals of the clap sequence detector.
// master drives the samples and the abort; slave is the detector itself.
interface clap_sequence_detector_if #(
   parameter int unsigned AMP_W     = 9,
   parameter int unsigned MAX_CLAPS = 4
);
   localparam int unsigned CNT_W = $clog2(MAX_CLAPS + 1);

   logic [AMP_W-1:0] amplitude_i;
   logic             clear_i;
   logic             clap_pulse_o;
   logic             seq_done_o;
   logic [CNT_W-1:0] seq_count_o;
   logic [AMP_W-1:0] level_o;

   modport master (
      output amplitude_i, clear_i,
      input  clap_pulse_o, seq_done_o, seq_count_o, level_o
   );

   modport slave (
      input  amplitude_i, clear_i,
      output clap_pulse_o, seq_done_o, seq_count_o, level_o
   );
endinterface

// File: rtl/clap_sequence_detector.sv
// Clap detector: offset from mid-scale, threshold + rising edge, holdoff
// rate limit, and grouping of claps into sequences closed by a silence window.
module clap_sequence_detector #(
   parameter int unsigned AMP_W     = 9,
   parameter int unsigned AMP_THR   = 8,
   parameter int unsigned HOLDOFF   = 300_000,
   parameter int unsigned WINDOW    = 3_000_000,
   parameter int unsigned MAX_CLAPS = 4
) (
   input  logic                      M_CLK,
   input  logic                      rst_i,
   clap_sequence_detector_if.slave   bus
);
   localparam int unsigned CENTER = 1 << (AMP_W - 1);
   localparam int unsigned CNT_W  = $clog2(MAX_CLAPS + 1);
   localparam int unsigned HOLD_W = $clog2(HOLDOFF + 1);
   localparam int unsigned GAP_W  = $clog2(WINDOW + 1);

   typedef enum logic {IDLE, COUNTING} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic [CNT_W-1:0] seq_count_q, seq_count_d;
   logic             clap_pulse_q, clap_pulse_d;
   logic             seq_done_q, seq_done_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [AMP_W-1:0] level_q, level_c;
   logic [AMP_W:0]   diff_c;
   logic             on_clap_q, on_clap_prev_q;
   logic             edge_c, accept_c;

   // Distance from mid-scale; the widened subtraction keeps the sign bit.
   assign diff_c  = {1'b0, bus.amplitude_i} - (AMP_W+1)'(CENTER);
   assign level_c = diff_c[AMP_W] ? AMP_W'((AMP_W+1)'(0) - diff_c)
                                  : diff_c[AMP_W-1:0];

   assign edge_c   = on_clap_q & ~on_clap_prev_q;
   // An abort in the same cycle swallows the clap and leaves holdoff alone.
   assign accept_c = edge_c && (hold_q == HOLD_W'(HOLDOFF)) && !bus.clear_i;

   always_comb begin
      hold_d = hold_q;
      if (accept_c)
         hold_d = '0;
      else if (hold_q != HOLD_W'(HOLDOFF))
         hold_d = hold_q + HOLD_W'(1);
   end

   always_ff @(posedge M_CLK or posedge rst_i) begin
      if (rst_i) begin
         level_q        <= '0;
         on_clap_q      <= 1'b0;
         on_clap_prev_q <= 1'b0;
         hold_q         <= HOLD_W'(HOLDOFF);
      end else begin
         level_q        <= level_c;
         on_clap_q      <= (level_q > AMP_W'(AMP_THR));
         on_clap_prev_q <= on_clap_q;
         hold_q         <= hold_d;
      end
   end

   always_ff @(posedge M_CLK or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         count_q      <= '0;
         gap_q        <= '0;
         seq_count_q  <= '0;
         clap_pulse_q <= 1'b0;
         seq_done_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         gap_q        <= gap_d;
         seq_count_q  <= seq_count_d;
         clap_pulse_q <= clap_pulse_d;
         seq_done_q   <= seq_done_d;
      end
   end

   // Sequence grouping; a clap landing on the window expiry extends the sequence.
   always_comb begin
      state_d      = state_q;
      count_d      = count_q;
      gap_d        = gap_q;
      seq_count_d  = seq_count_q;
      clap_pulse_d = 1'b0;
      seq_done_d   = 1'b0;
      if (bus.clear_i) begin
         state_d = IDLE;
         count_d = '0;
         gap_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept_c) begin
                  clap_pulse_d = 1'b1;
                  state_d      = COUNTING;
                  count_d      = CNT_W'(1);
                  gap_d        = '0;
               end
            end
            COUNTING: begin
               if (accept_c) begin
                  clap_pulse_d = 1'b1;
                  gap_d        = '0;
                  if (count_q + CNT_W'(1) == CNT_W'(MAX_CLAPS)) begin
                     seq_done_d  = 1'b1;
                     seq_count_d = CNT_W'(MAX_CLAPS);
                     state_d     = IDLE;
                     count_d     = '0;
                  end else begin
                     count_d = count_q + CNT_W'(1);
                  end
               end else if (gap_q == GAP_W'(WINDOW - 1)) begin
                  seq_done_d  = 1'b1;
                  seq_count_d = count_q;
                  state_d     = IDLE;
                  count_d     = '0;
                  gap_d       = '0;
               end else begin
                  gap_d = gap_q + GAP_W'(1);
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign bus.level_o      = level_q;
   assign bus.clap_pulse_o = clap_pulse_q;
   assign bus.seq_done_o   = seq_done_q;
   assign bus.seq_count_o  = seq_count_q;
endmodule

// File: tb/tb_clap_sequence_detector.sv
// Directed bench for clap_sequence_detector with small holdoff/window values.
module tb_clap_sequence_detector;
   localparam int unsigned AMP_W     = 9;
   localparam int unsigned MAX_CLAPS = 3;

   logic M_CLK;
   logic rst_i;
   int   cyc;
   int   n_checks;
   int   n_fail;
   int   pulse_q[$];
   int   done_q[$];
   int   dcnt_q[$];

   clap_sequence_detector_if #(.AMP_W(AMP_W), .MAX_CLAPS(MAX_CLAPS)) bus ();

   clap_sequence_detector #(
      .AMP_W(AMP_W), .AMP_THR(8), .HOLDOFF(10), .WINDOW(50), .MAX_CLAPS(MAX_CLAPS)
   ) dut (
      .M_CLK(M_CLK),
      .rst_i(rst_i),
      .bus  (bus)
   );

   initial M_CLK = 1'b0;
   always #5 M_CLK = ~M_CLK;

   always @(posedge M_CLK) cyc <= cyc + 1;

   // Event log sampled on the falling edge, away from the active edge.
   always @(negedge M_CLK) begin
      if (!rst_i) begin
         if (bus.clap_pulse_o) pulse_q.push_back(cyc);
         if (bus.seq_done_o) begin
            done_q.push_back(cyc);
            dcnt_q.push_back(int'(bus.seq_count_o));
         end
      end
   end

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int at(input int q[$], input int i);
      if (i < q.size()) return q[i];
      return -1000;
   endfunction

   task automatic step();
      @(posedge M_CLK);
      #1;
   endtask

   task automatic hold(input int v, input int n);
      bus.amplitude_i = AMP_W'(v);
      repeat (n) step();
      bus.amplitude_i = AMP_W'(256);
   endtask

   task automatic idle(input int n);
      bus.amplitude_i = AMP_W'(256);
      repeat (n) step();
   endtask

   task automatic clear_log();
      pulse_q.delete();
      done_q.delete();
      dcnt_q.delete();
   endtask

   int c0, c1;

   initial begin
      cyc = 0; n_checks = 0; n_fail = 0;
      rst_i = 1'b1;
      bus.amplitude_i = AMP_W'(256);
      bus.clear_i = 1'b0;
      repeat (3) step();
      check("rst_level", int'(bus.level_o), 0);
      check("rst_pulse", int'(bus.clap_pulse_o), 0);
      check("rst_done", int'(bus.seq_done_o), 0);
      check("rst_count", int'(bus.seq_count_o), 0);
      rst_i = 1'b0;

      // 1. threshold and latency
      idle(20);
      check("quiet_level", int'(bus.level_o), 0);
      check("quiet_pulses", pulse_q.size(), 0);
      c0 = cyc;
      bus.amplitude_i = AMP_W'(265);
      step();
      check("lvl_265", int'(bus.level_o), 9);
      idle(10);
      check("thr_pulses", pulse_q.size(), 1);
      check("thr_latency", at(pulse_q, 0) - c0, 3);
      idle(15);
      bus.amplitude_i = AMP_W'(264);
      step();
      check("lvl_264", int'(bus.level_o), 8);
      idle(10);
      check("at_thr_none", pulse_q.size(), 1);
      c0 = cyc;
      bus.amplitude_i = AMP_W'(247);
      step();
      check("lvl_247", int'(bus.level_o), 9);
      idle(10);
      check("low_pulses", pulse_q.size(), 2);
      check("low_latency", at(pulse_q, 1) - c0, 3);
      idle(80);
      clear_log();

      // 2. holdoff
      hold(300, 1); idle(4); hold(300, 1); idle(20);
      check("hold_5apart", pulse_q.size(), 1);
      idle(80); clear_log();
      hold(300, 1); idle(11); hold(300, 1); idle(20);
      check("hold_12apart", pulse_q.size(), 2);
      check("hold_12gap", at(pulse_q, 1) - at(pulse_q, 0), 12);
      idle(80); clear_log();
      hold(300, 40); idle(10);
      check("hold_level", pulse_q.size(), 1);
      idle(80); clear_log();

      // 3. single clap
      hold(300, 1); idle(80);
      check("single_pulses", pulse_q.size(), 1);
      check("single_dones", done_q.size(), 1);
      check("single_window", at(done_q, 0) - at(pulse_q, 0), 50);
      check("single_cnt", at(dcnt_q, 0), 1);
      check("single_held", int'(bus.seq_count_o), 1);
      clear_log();

      // 4. max claps
      hold(300, 1); idle(19); hold(300, 1); idle(19);
      hold(300, 1); idle(19); hold(300, 1); idle(80);
      check("max_pulses", pulse_q.size(), 4);
      check("max_dones", done_q.size(), 2);
      check("max_coincide", at(done_q, 0) - at(pulse_q, 2), 0);
      check("max_cnt", at(dcnt_q, 0), 3);
      check("max_next_win", at(done_q, 1) - at(pulse_q, 3), 50);
      check("max_next_cnt", at(dcnt_q, 1), 1);
      clear_log();

      // 5. window boundary
      hold(300, 1); idle(49); hold(300, 1); idle(80);
      check("w50_gap", at(pulse_q, 1) - at(pulse_q, 0), 50);
      check("w50_dones", done_q.size(), 1);
      check("w50_win", at(done_q, 0) - at(pulse_q, 1), 50);
      check("w50_cnt", at(dcnt_q, 0), 2);
      idle(20); clear_log();
      hold(300, 1); idle(50); hold(300, 1); idle(80);
      check("w51_gap", at(pulse_q, 1) - at(pulse_q, 0), 51);
      check("w51_dones", done_q.size(), 2);
      check("w51_first", at(done_q, 0) - at(pulse_q, 0), 50);
      check("w51_cnt0", at(dcnt_q, 0), 1);
      check("w51_second", at(done_q, 1) - at(pulse_q, 1), 50);
      check("w51_cnt1", at(dcnt_q, 1), 1);
      clear_log();

      // 6. abort: clear on the accept cycle drops the clap, holdoff untouched
      hold(300, 1); step();
      bus.clear_i = 1'b1; step(); bus.clear_i = 1'b0;
      idle(4);
      c1 = cyc;
      hold(300, 1);
      idle(12);
      bus.clear_i = 1'b1; step(); bus.clear_i = 1'b0;
      idle(80);
      check("clr_pulses", pulse_q.size(), 1);
      check("clr_kept_hold", at(pulse_q, 0) - c1, 3);
      check("clr_dones", done_q.size(), 0);
      check("clr_count", int'(bus.seq_count_o), 1);
      clear_log();

      // async reset mid-sequence
      hold(300, 1); idle(10);
      bus.amplitude_i = AMP_W'(300);
      step();
      check("pre_rst_level", int'(bus.level_o), 44);
      #3 rst_i = 1'b1;
      #1;
      check("arst_level", int'(bus.level_o), 0);
      check("arst_count", int'(bus.seq_count_o), 0);
      check("arst_pulse", int'(bus.clap_pulse_o), 0);
      check("arst_done", int'(bus.seq_done_o), 0);
      bus.amplitude_i = AMP_W'(256);
      step(); step();
      rst_i = 1'b0;
      clear_log();
      c0 = cyc;
      hold(300, 1); idle(80);
      check("post_rst_pulses", pulse_q.size(), 1);
      check("post_rst_lat", at(pulse_q, 0) - c0, 3);
      check("post_rst_dones", done_q.size(), 1);
      check("post_rst_win", at(done_q, 0) - at(pulse_q, 0), 50);
      check("post_rst_cnt", at(dcnt_q, 0), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
